// File: rtl/nios2_pio_in_capture.sv
// Synchronized PIO input port with sticky per-bit edge capture and a masked level irq.
// readdata valid one cycle after the read strobe; no wait states, the slave never stalls.
module nios2_pio_in_capture #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  // Edge detection opens once sync_last and prev both hold post-reset samples.
  localparam logic [2:0] INH_DONE = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync_last;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_raw;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] cap;
  logic [2:0]       inh_cnt;
  logic             rd_en;
  logic             wr_en;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  assign sync_last    = sync_q[SYNC_STAGES-1];
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev   <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
      prev   <= sync_last;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inh_cnt <= '0;
    end else if (inh_cnt != INH_DONE) begin
      inh_cnt <= inh_cnt + 3'd1;
    end
  end

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign edge_raw = sync_last & ~prev;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign edge_raw = ~sync_last & prev;
    end else begin : g_any
      assign edge_raw = sync_last ^ prev;
    end
  endgenerate

  assign edge_det = (inh_cnt == INH_DONE) ? edge_raw : '0;

  assign rd_en = chipselect & ~read_n;
  assign wr_en = chipselect & ~write_n;
  assign clr   = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : '0;

  // A same-cycle edge wins over a W1C clear of the same bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask <= '0;
      cap  <= '0;
    end else begin
      if (wr_en && address == 2'd1) begin
        mask <= writedata[WIDTH-1:0];
      end
      cap <= (cap & ~clr) | edge_det;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = sync_last;
      2'd1:    rd_mux[WIDTH-1:0] = mask;
      2'd2:    rd_mux[WIDTH-1:0] = cap;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else if (rd_en) begin
      readdata <= rd_mux;
    end
  end

  assign irq = |(cap & mask);

endmodule

// File: tb/tb_nios2_pio_in_capture.sv
// Bench for nios2_pio_in_capture: rising, falling and any-edge instances share one bus,
// checked every cycle against a sample-history reference model plus directed constants.
module tb_nios2_pio_in_capture;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] rdata0, rdata1, rdata2;
  logic        irq0, irq1, irq2;

  always #5 clk = ~clk;

  nios2_pio_in_capture #(.WIDTH(8), .SYNC_STAGES(S), .EDGE_TYPE(0)) dut_rise (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rdata0), .irq(irq0)
  );
  nios2_pio_in_capture #(.WIDTH(8), .SYNC_STAGES(S), .EDGE_TYPE(1)) dut_fall (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rdata1), .irq(irq1)
  );
  nios2_pio_in_capture #(.WIDTH(8), .SYNC_STAGES(S), .EDGE_TYPE(2)) dut_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rdata2), .irq(irq2)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: hist[k] is the input sampled at edge k+1 after reset release.
  logic [7:0]  hist [0:8191];
  int          ecount;
  logic [7:0]  mask_m;
  logic [7:0]  cap_m [3];
  logic [31:0] rd_m  [3];
  logic [7:0]  cur_in;

  task automatic model_reset();
    ecount = 0;
    mask_m = 8'h00;
    for (int t = 0; t < 3; t++) begin
      cap_m[t] = 8'h00;
      rd_m[t]  = 32'h0;
    end
  endtask

  task automatic model_edge(input logic cs, input logic r, input logic w,
                            input logic [1:0] a, input logic [31:0] wd, input logic [7:0] inv);
    int         m;
    logic [7:0] data_pre, pa, pb, clr;
    logic [7:0] ev [3];
    ecount++;
    m = ecount;
    hist[m-1] = inv;
    // The data register shows the input sampled S edges before this one.
    data_pre = (m - 1 - S >= 0) ? hist[m-1-S] : 8'h00;
    for (int t = 0; t < 3; t++) ev[t] = 8'h00;
    if (m >= S + 2) begin
      pa = hist[m-S-2];
      pb = hist[m-S-1];
      ev[0] = pb & ~pa;
      ev[1] = pa & ~pb;
      ev[2] = pa ^ pb;
    end
    if (cs && r) begin
      for (int t = 0; t < 3; t++) begin
        case (a)
          2'd0: rd_m[t] = {24'h0, data_pre};
          2'd1: rd_m[t] = {24'h0, mask_m};
          2'd2: rd_m[t] = {24'h0, cap_m[t]};
          default: rd_m[t] = 32'h0;
        endcase
      end
    end
    clr = (cs && w && a == 2'd2) ? wd[7:0] : 8'h00;
    if (cs && w && a == 2'd1) mask_m = wd[7:0];
    for (int t = 0; t < 3; t++) cap_m[t] = (cap_m[t] & ~clr) | ev[t];
  endtask

  task automatic check_all();
    chk("rd_rise",  rdata0, rd_m[0]);
    chk("rd_fall",  rdata1, rd_m[1]);
    chk("rd_any",   rdata2, rd_m[2]);
    chk("irq_rise", {31'h0, irq0}, {31'h0, |(cap_m[0] & mask_m)});
    chk("irq_fall", {31'h0, irq1}, {31'h0, |(cap_m[1] & mask_m)});
    chk("irq_any",  {31'h0, irq2}, {31'h0, |(cap_m[2] & mask_m)});
  endtask

  // Called at a negedge; drives one bus cycle, checks after the edge, returns at the next negedge.
  task automatic step(input logic cs, input logic r, input logic w,
                      input logic [1:0] a, input logic [31:0] wd);
    chipselect = cs;
    read_n     = ~r;
    write_n    = ~w;
    address    = a;
    writedata  = wd;
    in_port    = cur_in;
    @(posedge clk);
    model_edge(cs, r, w, a, wd, cur_in);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  task automatic rd(input logic [1:0] a);
    step(1'b1, 1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    step(1'b1, 1'b0, 1'b1, a, d);
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_rd_rise",  rdata0, 32'h0);
    chk("rst_rd_fall",  rdata1, 32'h0);
    chk("rst_rd_any",   rdata2, 32'h0);
    chk("rst_irq_rise", {31'h0, irq0}, 32'h0);
    chk("rst_irq_any",  {31'h0, irq2}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    chipselect = 1'b0;
    read_n     = 1'b1;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = 32'h0;
    cur_in     = 8'hFF;
    in_port    = 8'hFF;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("por_rdata", rdata0, 32'h0);
    chk("por_irq", {31'h0, irq0}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Reset and idle with inputs high through reset.
    repeat (10) idle();
    rd(2'd0); chk("idle_data", rdata0, 32'hFF);
    rd(2'd1); chk("idle_mask", rdata0, 32'h0);
    rd(2'd2); chk("idle_cap_rise", rdata0, 32'h0);
    chk("idle_cap_fall", rdata1, 32'h0);
    chk("idle_cap_any", rdata2, 32'h0);
    rd(2'd3); chk("idle_rsvd", rdata0, 32'h0);

    // Rising capture and irq latency.
    wr(2'd1, 32'h05);
    cur_in = 8'h00;
    repeat (4) idle();
    wr(2'd2, 32'hFF);
    idle();
    cur_in = 8'h0F;
    n = 0;
    do begin
      idle();
      n++;
    end while (!irq0 && n < 20);
    chk("irq_latency", n, S + 1);
    repeat (2) idle();
    rd(2'd2); chk("cap_0f", rdata0, 32'h0F);
    wr(2'd2, 32'h05);
    chk("irq_cleared", {31'h0, irq0}, 32'h0);
    rd(2'd2); chk("cap_0a", rdata0, 32'h0A);

    // Edge and clear land on the same cycle: edge wins.
    cur_in = 8'h0E;
    repeat (4) idle();
    wr(2'd2, 32'hFF);
    cur_in = 8'h0F;
    idle();
    repeat (S - 1) idle();
    wr(2'd2, 32'h01);
    rd(2'd2); chk("collide_keep", rdata0, 32'h01);
    wr(2'd2, 32'h01);
    rd(2'd2); chk("collide_clear", rdata0, 32'h00);

    // Edge type variants on bit 3.
    cur_in = 8'h00;
    repeat (4) idle();
    wr(2'd2, 32'hFF);
    cur_in = 8'h08;
    repeat (S + 2) idle();
    rd(2'd2);
    chk("up_rise", rdata0, 32'h08);
    chk("up_fall", rdata1, 32'h00);
    chk("up_any",  rdata2, 32'h08);
    wr(2'd2, 32'hFF);
    cur_in = 8'h00;
    repeat (S + 2) idle();
    rd(2'd2);
    chk("dn_rise", rdata0, 32'h00);
    chk("dn_fall", rdata1, 32'h08);
    chk("dn_any",  rdata2, 32'h08);

    // Bus behaviour.
    cur_in = 8'h5A;
    repeat (4) idle();
    wr(2'd0, 32'h12345678);
    rd(2'd0); chk("data_ro", rdata0, 32'h5A);
    wr(2'd1, 32'h33);
    step(1'b1, 1'b1, 1'b1, 2'd1, 32'hAA);
    chk("rw_old_mask", rdata0, 32'h33);
    rd(2'd1); chk("rw_new_mask", rdata0, 32'hAA);

    // Reset mid-operation with irq asserted and readdata nonzero.
    cur_in = 8'hFA;
    repeat (S + 2) idle();
    chk("pre_rst_irq", {31'h0, irq0}, 32'h1);
    rd(2'd1);
    pulse_reset();
    repeat (6) idle();
    rd(2'd1); chk("post_rst_mask", rdata0, 32'h0);
    rd(2'd2); chk("post_rst_cap", rdata0, 32'h0);
    chk("post_rst_cap_any", rdata2, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 2) == 0) cur_in = cur_in ^ 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) cur_in = 8'($urandom_range(0, 255));
      if (i % 700 == 699) pulse_reset();
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nios2_pio_in_capture.md
# nios2_pio_in_capture

Avalon-MM slave input port for the nios2 subsystem, the input-direction counterpart of the PIO output ports that drive audio-path control lines. It synchronizes a `WIDTH`-bit external input bus into `clk` and exposes the current level to software. It latches selected edges per bit into a sticky capture register and raises a maskable level interrupt to the Nios II. Typical uses are AGC status and level-detect flags and button inputs.

## Interface

- `WIDTH`, default 8: number of input bits; legal range 1..32.
- `SYNC_STAGES`, default 2: synchronizer depth; legal range 2..4.
- `EDGE_TYPE`, default 0: 0 = rising, 1 = falling, 2 = any edge.

- `clk`  in  1  system clock; all logic is in this single domain.
- `reset`  in  1  asynchronous, active-high reset.
- `address`  in  2  register select.
- `chipselect`  in  1  slave select.
- `read_n`  in  1  active-low read strobe, qualified by `chipselect`.
- `write_n`  in  1  active-low write strobe, qualified by `chipselect`.
- `writedata`  in  32  write data.
- `in_port`  in  WIDTH  asynchronous external inputs.
- `readdata`  out  32  registered read data; bits above WIDTH-1 read 0.
- `irq`  out  1  level interrupt, active-high.

## Operation

- **Synchronizer.** `in_port` passes through `SYNC_STAGES` flops, then one further delay flop `prev`.
- **Edge detection.** `edge` is derived from `sync_last` and `prev`:
  - rising: `sync_last & ~prev`
  - falling: `~sync_last & prev`
  - any: XOR of the two.
- **Start-up inhibit.** A counter from 0 to `SYNC_STAGES`+1 holds `edge` at 0 after reset until the chain holds real samples. No spurious capture occurs for inputs that are static through reset.
- **Register map.** The register at 3 is reserved.
  - Address 0, data (RO): `sync_last`. Writes are ignored.
  - Address 1, irq mask (RW): a write loads `writedata[WIDTH-1:0]`.
  - Address 2, edge capture (R/W1C): a write clears each bit where the `writedata` bit is 1.
  - Address 3: reads return 0 and writes are ignored.
- **Capture update.** Each cycle: `cap <= (cap & ~clr) | edge`. If an edge and a clear hit the same bit in the same cycle, the edge wins and the bit stays set.
- **Interrupt.** `irq = |(cap & mask)`, driven combinationally from flops with no added latency.
- **Read/write collision.** When read and write are both active in the same cycle, the write takes effect and `readdata` returns the pre-write value.
- **Reset.** All of the following clear to 0 asynchronously: sync chain, `prev`, inhibit counter, `mask`, `cap`, `readdata`, `irq`.
- **Reset mid-operation.** It discards pending captures and restarts the inhibit window.

## Timing

- **Read latency is 1.** `readdata` updates on the rising edge after the cycle in which `chipselect && !read_n`.
  - It holds its value until the next read.
  - No wait states; `readdata` is not cleared between reads.
- **Writes** take effect on the rising edge ending the strobe cycle.
- **Input-to-data latency.** A change on `in_port` that is set up before edge 1 is visible in the data register after edge `SYNC_STAGES`.
  - A read strobed in the following cycle returns the new value.
- **Input-to-capture latency.** The capture bit and `irq` assert after edge `SYNC_STAGES`+1, i.e. edge 3 at default depth.
- **Minimum pulse width.** Input pulses shorter than one `clk` period may be missed; pulses of 2 or more periods are always seen.
- **Inhibit window.** Edge detection is enabled from the edge `SYNC_STAGES`+2 after reset deassertion onward.

## Test plan

- **Reset and idle.** Hold `reset` high with `in_port`=8'hFF, release, wait 10 cycles, then read addresses 0/1/2/3.
  - Reads return 32'hFF, 0, 0, 0.
  - `irq` stays 0 throughout; no spurious capture.
- **Rising capture and irq.** Write mask=8'h05, then drive `in_port` 0→8'h0F.
  - Capture reads 8'h0F.
  - `irq` rises exactly `SYNC_STAGES`+1 edges after the input change.
  - Write 8'h05 to address 2: `irq` falls the next cycle and capture reads 8'h0A.
- **Edge/clear collision.** Time a write of 8'h01 to address 2 onto the same cycle bit 0 sees a new rising edge.
  - Bit 0 remains 1.
  - Repeat with no edge present: bit 0 clears.
- **EDGE_TYPE variants.** Toggle bit 3 once high and once low.
  - `EDGE_TYPE`=1: only the falling transition is captured.
  - `EDGE_TYPE`=2: both are captured, each after clearing.
  - A 1-cycle pulse with `EDGE_TYPE`=0 at 2 stages is not required to be captured.
- **Bus behaviour.**
  - A write to address 0 does not change the read value.
  - A read of mask issued in the same cycle as a write of 8'hAA returns the old mask; the next read returns 32'h000000AA.
  - Assert `reset` mid-test: `irq`, capture, mask and `readdata` go 0 immediately.
